// File: rtl/namuru_corr_pkg.sv
// Shared definitions for the namuru correlator channel.
// Holds the sign/magnitude level constants, the product width and the
// sign/magnitude to two's complement conversion used by the mixers.
package namuru_corr_pkg;

   localparam int PROD_W  = 4;   // signed width holding any product in -6..+6
   localparam int RAW_LO  = 1;   // ADC sample, mag=0
   localparam int RAW_HI  = 3;   // ADC sample, mag=1
   localparam int CARR_LO = 1;   // carrier replica, mag=0
   localparam int CARR_HI = 2;   // carrier replica, mag=1

   // Sign/magnitude pair to signed value; sgn=1 means negative.
   function automatic logic signed [PROD_W-1:0] sm_to_signed(
      input logic sgn,
      input logic mag,
      input int   lo,
      input int   hi
   );
      logic signed [PROD_W-1:0] v;
      v = mag ? PROD_W'(hi) : PROD_W'(lo);
      return sgn ? -v : v;
   endfunction

endpackage

// File: rtl/sm_mult.sv
// Combinational 2-bit x 2-bit sign/magnitude multiplier (raw sample x carrier).
// Ports: raw_sign/raw_mag  ADC sample; carr_sign/carr_mag  carrier replica;
//        prod  signed product in -6..+6.
module sm_mult
   import namuru_corr_pkg::*;
(
   input  logic                     raw_sign,
   input  logic                     raw_mag,
   input  logic                     carr_sign,
   input  logic                     carr_mag,
   output logic signed [PROD_W-1:0] prod
);

   logic signed [PROD_W-1:0] raw_val;
   logic signed [PROD_W-1:0] carr_val;

   assign raw_val  = sm_to_signed(raw_sign, raw_mag, RAW_LO, RAW_HI);
   assign carr_val = sm_to_signed(carr_sign, carr_mag, CARR_LO, CARR_HI);
   // |product| <= 6, so truncation to PROD_W bits is exact.
   assign prod     = raw_val * carr_val;

endmodule

// File: rtl/carrier_wipeoff_accum.sv
// Carrier wipe-off and I/Q integrate-and-dump for one correlator channel.
// Ports: clk/rst (async, active-high); sample_enable qualifies raw_*, i_*, q_*,
//        code_bit and dump; i_accum/q_accum/overflow latched on dump with a
//        one-cycle accum_valid pulse. Sample at edge k lands in the sum at k+1.
module carrier_wipeoff_accum
   import namuru_corr_pkg::*;
#(
   parameter int ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_enable,
   input  logic                    raw_sign,
   input  logic                    raw_mag,
   input  logic                    i_sign,
   input  logic                    i_mag,
   input  logic                    q_sign,
   input  logic                    q_mag,
   input  logic                    code_bit,
   input  logic                    dump,
   output logic signed [ACC_W-1:0] i_accum,
   output logic signed [ACC_W-1:0] q_accum,
   output logic                    accum_valid,
   output logic                    overflow
);

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [PROD_W-1:0] prod_i, prod_q;

   // Stage 1: registered products plus the code chip and dump flag
   logic signed [PROD_W-1:0] s1_i, s1_q;
   logic                     s1_code, s1_dump, s1_vld;

   // Stage 2: running sums and sticky saturation flag
   logic signed [ACC_W-1:0]  acc_i, acc_q;
   logic                     sat;

   logic signed [PROD_W-1:0] term_i, term_q;
   logic signed [ACC_W:0]    sum_i, sum_q;
   logic signed [ACC_W-1:0]  next_i, next_q;
   logic                     ovf_i, ovf_q;

   sm_mult u_mult_i (
      .raw_sign  (raw_sign),
      .raw_mag   (raw_mag),
      .carr_sign (i_sign),
      .carr_mag  (i_mag),
      .prod      (prod_i)
   );

   sm_mult u_mult_q (
      .raw_sign  (raw_sign),
      .raw_mag   (raw_mag),
      .carr_sign (q_sign),
      .carr_mag  (q_mag),
      .prod      (prod_q)
   );

   // One guard bit above the accumulator: if it disagrees with the MSB the
   // add overflowed, and the guard bit gives the direction to clamp toward.
   always_comb begin
      term_i = s1_code ? s1_i : -s1_i;
      term_q = s1_code ? s1_q : -s1_q;
      sum_i  = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-PROD_W){term_i[PROD_W-1]}}, term_i};
      sum_q  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){term_q[PROD_W-1]}}, term_q};
      ovf_i  = sum_i[ACC_W] ^ sum_i[ACC_W-1];
      ovf_q  = sum_q[ACC_W] ^ sum_q[ACC_W-1];
      next_i = sum_i[ACC_W-1:0];
      next_q = sum_q[ACC_W-1:0];
      if (ovf_i) next_i = sum_i[ACC_W] ? ACC_MIN : ACC_MAX;
      if (ovf_q) next_q = sum_q[ACC_W] ? ACC_MIN : ACC_MAX;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_i        <= '0;
         s1_q        <= '0;
         s1_code     <= 1'b0;
         s1_dump     <= 1'b0;
         s1_vld      <= 1'b0;
         acc_i       <= '0;
         acc_q       <= '0;
         sat         <= 1'b0;
         i_accum     <= '0;
         q_accum     <= '0;
         overflow    <= 1'b0;
         accum_valid <= 1'b0;
      end else begin
         s1_vld      <= sample_enable;
         accum_valid <= 1'b0;
         if (sample_enable) begin
            s1_i    <= prod_i;
            s1_q    <= prod_q;
            s1_code <= code_bit;
            s1_dump <= dump;
         end
         if (s1_vld) begin
            if (s1_dump) begin
               // The dump sample closes the interval it belongs to.
               i_accum     <= next_i;
               q_accum     <= next_q;
               overflow    <= sat | ovf_i | ovf_q;
               accum_valid <= 1'b1;
               acc_i       <= '0;
               acc_q       <= '0;
               sat         <= 1'b0;
            end else begin
               acc_i <= next_i;
               acc_q <= next_q;
               sat   <= sat | ovf_i | ovf_q;
            end
         end
      end
   end

endmodule
